// File: rtl/instr_fetch_resp.sv
// Instruction memory with a wait-stated fetch response path and a program-load port.
// Loads are accepted only while idle; each fetch is answered by a single-cycle ack.
module instr_fetch_resp #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] HALT_WORD   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [7:0]  fetch_addr,
  output logic        fetch_ack,
  output logic [15:0] fetch_data,
  output logic        halt_seen,
  input  logic        load_en,
  input  logic [7:0]  load_addr,
  input  logic [15:0] load_data,
  output logic        load_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  state_t      state;
  logic [2:0]  wait_cnt;
  logic [7:0]  addr_q;
  logic [15:0] mem [256];

  // Storage has no reset so program contents survive rst.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= 3'd0;
      addr_q     <= 8'h00;
      fetch_ack  <= 1'b0;
      fetch_data <= 16'h0000;
      halt_seen  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          fetch_ack <= 1'b0;
          if (!load_en && fetch_req) begin
            addr_q   <= fetch_addr;
            wait_cnt <= WAIT_INIT;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
          end else begin
            fetch_data <= mem[addr_q];
            fetch_ack  <= 1'b1;
            if (mem[addr_q] == HALT_WORD) begin
              halt_seen <= 1'b1;
            end
            state <= S_RESP;
          end
        end
        S_RESP: begin
          fetch_ack <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          fetch_ack <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign load_busy = (state != S_IDLE);

endmodule
